// File: rtl/data_memory_mp.sv
// Multi-port data memory with power-up zero-fill and lowest-port-wins writes.
// Optional macro DATA_MEMORY_MP_WR_FWD_EN forwards same-cycle write data to reads.
module data_memory_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NPORTS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        we,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*DATA_W-1:0] wdata,
    output logic [NPORTS*DATA_W-1:0] rdata,
    output logic [NPORTS-1:0]        rvalid,
    output logic                     ready,
    output logic                     wr_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [ADDR_W-1:0]          cnt;
    logic [DATA_W-1:0]          mem [DEPTH];
    logic [NPORTS-1:0]          win;
    logic                       conflict;
    logic [NPORTS*DATA_W-1:0]   rd_val;
    logic                       restart;

    // A clear only counts while requests are being accepted
    assign restart = clear && ready;

    // Pick one winning writer per address; lower port index has priority
    always_comb begin
        win      = '0;
        conflict = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (req[p] && we[p]) begin
                win[p] = 1'b1;
                for (int q = 0; q < p; q++) begin
                    if (req[q] && we[q] &&
                        addr[q*ADDR_W +: ADDR_W] == addr[p*ADDR_W +: ADDR_W]) begin
                        win[p]   = 1'b0;
                        conflict = 1'b1;
                    end
                end
            end
        end
    end

    // Read data per port, optionally bypassing the winning same-cycle write
    always_comb begin
        rd_val = '0;
        for (int p = 0; p < NPORTS; p++) begin
            rd_val[p*DATA_W +: DATA_W] = mem[addr[p*ADDR_W +: ADDR_W]];
`ifdef DATA_MEMORY_MP_WR_FWD_EN
            for (int q = 0; q < NPORTS; q++) begin
                if (win[q] &&
                    addr[q*ADDR_W +: ADDR_W] == addr[p*ADDR_W +: ADDR_W]) begin
                    rd_val[p*DATA_W +: DATA_W] = wdata[q*DATA_W +: DATA_W];
                end
            end
`endif
        end
    end

    // Next state: fill until the last word is cleared, restart on clear
    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT: if (cnt == {ADDR_W{1'b1}}) state_nxt = RUN;
            RUN:  if (restart) state_nxt = INIT;
        endcase
    end

    // Control, status and read-port registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= INIT;
            cnt         <= '0;
            ready       <= 1'b0;
            rvalid      <= '0;
            wr_conflict <= 1'b0;
            rdata       <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
            end else if (restart) begin
                cnt <= '0;
            end
            ready       <= (state == RUN) && !restart;
            wr_conflict <= ready && conflict;
            for (int p = 0; p < NPORTS; p++) begin
                rvalid[p] <= ready && req[p] && !we[p];
                if (ready && req[p] && !we[p]) begin
                    rdata[p*DATA_W +: DATA_W] <= rd_val[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Storage array: zero-fill during INIT, port writes while accepting
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[cnt] <= '0;
            end else if (ready) begin
                for (int p = 0; p < NPORTS; p++) begin
                    if (win[p]) begin
                        mem[addr[p*ADDR_W +: ADDR_W]] <= wdata[p*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_mp.sv
// Scoreboard bench for data_memory_mp: directed scenarios plus random traffic.
// Expected responses come from an array model of the memory and a ready timer.
module tb_data_memory_mp;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int NP    = 4;
    localparam int DEPTH = 256;

    logic             clock = 1'b0;
    logic             reset;
    logic             clear;
    logic [NP-1:0]    req;
    logic [NP-1:0]    we;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata;
    logic [NP*DW-1:0] rdata;
    logic [NP-1:0]    rvalid;
    logic             ready;
    logic             wr_conflict;

    data_memory_mp #(.DATA_W(DW), .ADDR_W(AW), .NPORTS(NP)) dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .ready       (ready),
        .wr_conflict (wr_conflict)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          rst;
        logic          rdy;
        logic          conf;
        logic [NP-1:0] rv;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] data_q[$];
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] last_rd [NP];
    logic          rdy_m = 1'b0;
    int            wait_m = 0;
    int            checks = 0;
    int            fails = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: one expected record per clock edge, data popped per valid read
    initial begin
        exp_t          e;
        logic [DW-1:0] d;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ready", 64'(ready), 64'(e.rdy));
                check("wr_conflict", 64'(wr_conflict), 64'(e.conf));
                check("rvalid", 64'(rvalid), 64'(e.rv));
                for (int p = 0; p < NP; p++) begin
                    if (e.rst) last_rd[p] = '0;
                    if (e.rv[p]) begin
                        d = data_q.pop_front();
                        last_rd[p] = d;
                    end
                    check($sformatf("rdata%0d", p),
                          64'(rdata[p*DW +: DW]), 64'(last_rd[p]));
                end
            end
        end
    end

    // Drive one cycle of inputs and predict the response of the next edge
    task automatic cycle(input logic rst, input logic clr,
                         input logic [NP-1:0] rq, input logic [NP-1:0] w,
                         input logic [NP*AW-1:0] ad, input logic [NP*DW-1:0] wd);
        exp_t          e;
        logic [AW-1:0] wa [NP];
        logic [DW-1:0] wv [NP];
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        logic          dup;
        int            nw;
        reset = rst;
        clear = clr;
        req   = rq;
        we    = w;
        addr  = ad;
        wdata = wd;
        e     = '0;
        e.rst = rst;
        nw    = 0;
        if (rst) begin
            rdy_m  = 1'b0;
            wait_m = 257;
            for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        end else if (rdy_m) begin
            for (int p = 0; p < NP; p++) begin
                if (rq[p] && w[p]) begin
                    a   = ad[p*AW +: AW];
                    dup = 1'b0;
                    for (int i = 0; i < nw; i++) if (wa[i] == a) dup = 1'b1;
                    if (dup) e.conf = 1'b1;
                    else begin
                        wa[nw] = a;
                        wv[nw] = wd[p*DW +: DW];
                        nw++;
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (rq[p] && !w[p]) begin
                    a = ad[p*AW +: AW];
                    v = mm[a];
`ifdef DATA_MEMORY_MP_WR_FWD_EN
                    for (int i = 0; i < nw; i++) if (wa[i] == a) v = wv[i];
`endif
                    data_q.push_back(v);
                    e.rv[p] = 1'b1;
                end
            end
            for (int i = 0; i < nw; i++) mm[wa[i]] = wv[i];
            if (clr) begin
                rdy_m  = 1'b0;
                wait_m = 257;
                for (int i = 0; i < DEPTH; i++) mm[i] = '0;
            end
        end else begin
            wait_m--;
            if (wait_m == 0) rdy_m = 1'b1;
        end
        e.rdy = rdy_m;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic op(input int p, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
        logic [NP*AW-1:0] ad;
        logic [NP*DW-1:0] wd;
        ad = '0;
        wd = '0;
        ad[p*AW +: AW] = a;
        wd[p*DW +: DW] = d;
        cycle(1'b0, 1'b0, NP'(1) << p, NP'(w) << p, ad, wd);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!rdy_m && n < 400) begin
            idle(1);
            n++;
        end
    endtask

    initial begin
        logic [NP*AW-1:0] ad;
        logic [NP*DW-1:0] wd;
        logic             r;
        logic             c;

        // Reset, full fill, then read every word back on all four ports
        cycle(1'b1, 1'b0, '0, '0, '0, '0);
        cycle(1'b1, 1'b1, 4'hF, 4'h5, '0, '1);
        wait_ready();
        for (int b = 0; b < DEPTH; b += NP) begin
            for (int p = 0; p < NP; p++) ad[p*AW +: AW] = AW'(b + p);
            cycle(1'b0, 1'b0, 4'hF, 4'h0, ad, '0);
        end

        // Write on port 0, read back on port 3
        op(0, 1'b1, 8'h10, 16'hBEEF);
        op(3, 1'b0, 8'h10, 16'h0000);
        idle(1);

        // Ports 1 and 2 collide on 0x20; port 1 must win
        ad = '0;
        wd = '0;
        ad[1*AW +: AW] = 8'h20;
        ad[2*AW +: AW] = 8'h20;
        wd[1*DW +: DW] = 16'h1111;
        wd[2*DW +: DW] = 16'h2222;
        cycle(1'b0, 1'b0, 4'b0110, 4'b0110, ad, wd);
        idle(1);
        op(0, 1'b0, 8'h20, 16'h0000);

        // Same-cycle write on port 0 and read on port 1 of 0x30
        ad = '0;
        wd = '0;
        ad[0*AW +: AW] = 8'h30;
        ad[1*AW +: AW] = 8'h30;
        wd[0*DW +: DW] = 16'hAAAA;
        cycle(1'b0, 1'b0, 4'b0011, 4'b0001, ad, wd);
        op(2, 1'b0, 8'h30, 16'h0000);

        // Clear restarts the fill; requests during INIT are ignored
        op(0, 1'b1, 8'h40, 16'h5555);
        op(1, 1'b0, 8'h40, 16'h0000);
        cycle(1'b0, 1'b1, 4'b0001, 4'b0000, 32'h40, '0);
        op(0, 1'b0, 8'h40, 16'h0000);
        op(2, 1'b1, 8'h41, 16'h7777);
        idle(50);
        cycle(1'b0, 1'b1, '0, '0, '0, '0);
        wait_ready();
        op(0, 1'b0, 8'h40, 16'h0000);
        op(1, 1'b0, 8'h41, 16'h0000);

        // Reset at fill count 100 restarts the fill from zero
        op(0, 1'b1, 8'h50, 16'h1234);
        cycle(1'b1, 1'b0, '0, '0, '0, '0);
        idle(100);
        cycle(1'b1, 1'b0, '0, '0, '0, '0);
        wait_ready();
        op(3, 1'b0, 8'h50, 16'h0000);

        // Random traffic with a narrow address window to provoke collisions
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 499) == 0);
            c = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < NP; p++) begin
                ad[p*AW +: AW] = ($urandom_range(0, 3) == 0) ?
                                 AW'($urandom) : AW'($urandom_range(0, 7));
                wd[p*DW +: DW] = DW'($urandom);
            end
            cycle(r, c, NP'($urandom), NP'($urandom), ad, wd);
        end
        wait_ready();
        for (int b = 0; b < 8; b += NP) begin
            for (int p = 0; p < NP; p++) ad[p*AW +: AW] = AW'(b + p);
            cycle(1'b0, 1'b0, 4'hF, 4'h0, ad, '0);
        end
        idle(3);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("data_q_drained", 64'(data_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
